m31_mul_arbiter: RTL and testbench

M31_MUL_ARBITER -- requirements
Module: m31_mul_arbiter

---
 rtl/m31_mul_arbiter.sv | 111 +++++++++++
 tb/tb_m31_mul_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/m31_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined M31 multiplier among NREQ requesters.
// A tag pipeline follows each operation so its result is routed back to the owner.
module m31_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid_i,
  input  logic [NREQ*31-1:0]  req_a_i,
  input  logic [NREQ*31-1:0]  req_b_i,
  output logic [NREQ-1:0]     req_ready_o,
  output logic [30:0]         mul_a_o,
  output logic [30:0]         mul_b_o,
  input  logic [30:0]         mul_res_i,
  output logic [NREQ-1:0]     rsp_valid_o,
  output logic [30:0]         rsp_data_o,
  output logic                busy_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MUL_LAT + 1);

  logic [IW-1:0]   r_ptr;
  logic [MUL_LAT-1:0] r_tag_vld;
  logic [IW-1:0]   r_tag_idx [MUL_LAT];
  logic [NREQ-1:0] r_rsp_valid;
  logic [CW-1:0]   r_cnt;

  logic            w_gnt_vld;
  logic [IW-1:0]   w_gnt_idx;
  logic [IW-1:0]   w_cand;
  logic [NREQ-1:0] w_ready;
  logic [30:0]     w_mul_a;
  logic [30:0]     w_mul_b;
  logic            w_ret;

  // Round-robin search starting one past the last granted requester; no grant in reset.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    if (!rst_n) begin
      for (int k = 1; k <= NREQ; k++) begin
        w_cand = IW'((int'(r_ptr) + k) % NREQ);
        if (!w_gnt_vld && req_valid_i[w_cand]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = w_cand;
        end else begin
          w_gnt_vld = w_gnt_vld;
        end
      end
    end else begin
      w_gnt_vld = 1'b0;
    end
  end

  // Decode the grant into the one-hot ready and the multiplier operand mux.
  always_comb begin
    w_ready = '0;
    w_mul_a = 31'd0;
    w_mul_b = 31'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_vld && (w_gnt_idx == IW'(i))) begin
        w_ready[i] = 1'b1;
        w_mul_a    = req_a_i[31*i +: 31];
        w_mul_b    = req_b_i[31*i +: 31];
      end else begin
        w_ready[i] = 1'b0;
      end
    end
  end

  assign w_ret = r_tag_vld[MUL_LAT-1];

  // Tag pipeline, response strobe, round-robin pointer and outstanding counter.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_ptr       <= IW'(NREQ - 1);
      r_tag_vld   <= '0;
      for (int i = 0; i < MUL_LAT; i++) r_tag_idx[i] <= '0;
      r_rsp_valid <= '0;
      r_cnt       <= '0;
    end else begin
      for (int i = MUL_LAT - 1; i > 0; i--) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_idx[i] <= r_tag_idx[i-1];
      end
      r_tag_vld[0] <= w_gnt_vld;
      r_tag_idx[0] <= w_gnt_idx;
      for (int i = 0; i < NREQ; i++) begin
        r_rsp_valid[i] <= w_ret && (r_tag_idx[MUL_LAT-1] == IW'(i));
      end
      if (w_gnt_vld) r_ptr <= w_gnt_idx;
      // Saturating guards keep the counter inside 0..MUL_LAT even if the pipeline misbehaves.
      case ({w_gnt_vld, w_ret})
        2'b10:   if (r_cnt != CW'(MUL_LAT)) r_cnt <= r_cnt + CW'(1);
        2'b01:   if (r_cnt != CW'(0))       r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign req_ready_o = w_ready;
  assign mul_a_o     = w_mul_a;
  assign mul_b_o     = w_mul_b;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = mul_res_i;
  assign busy_o      = (r_cnt != CW'(0));

endmodule

// File: tb/tb_m31_mul_arbiter.sv
// Bench for m31_mul_arbiter: behavioural multiplier, table vectors, corner sequences
// and a randomized run against a queue-based scoreboard.
module tb_m31_mul_arbiter;

  localparam int NREQ    = 4;
  localparam int MUL_LAT = 4;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ*31-1:0] req_a_i;
  logic [NREQ*31-1:0] req_b_i;
  logic [NREQ-1:0]    req_ready_o;
  logic [30:0]        mul_a_o;
  logic [30:0]        mul_b_o;
  logic [30:0]        mul_res_i;
  logic [NREQ-1:0]    rsp_valid_o;
  logic [30:0]        rsp_data_o;
  logic               busy_o;

  m31_mul_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .req_ready_o(req_ready_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_res_i(mul_res_i), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [30:0] mulmod(input logic [30:0] a, input logic [30:0] b);
    logic [63:0] prod;
    prod = {33'd0, a} * {33'd0, b};
    return 31'(prod % 64'h7fff_ffff);
  endfunction

  // Behavioural multiplier: operands sampled at edge E, product visible after edge E+MUL_LAT.
  logic [30:0] mpipe [0:MUL_LAT];
  always @(posedge clk) begin
    for (int i = MUL_LAT; i > 0; i--) mpipe[i] <= mpipe[i-1];
    mpipe[0] <= mulmod(mul_a_o, mul_b_o);
  end
  assign mul_res_i = mpipe[MUL_LAT];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pending results in issue order, each with its owner and due cycle.
  typedef struct { int owner; logic [30:0] data; int due; } pend_t;
  pend_t sb[$];
  int cyc;
  int last_gnt;
  int granted;
  logic [NREQ-1:0] vld;
  logic [30:0] a_op [NREQ];
  logic [30:0] b_op [NREQ];

  task automatic drive();
    req_valid_i = vld;
    for (int i = 0; i < NREQ; i++) begin
      req_a_i[31*i +: 31] = a_op[i];
      req_b_i[31*i +: 31] = b_op[i];
    end
  endtask

  // One cycle: check the grant at this negedge, then advance and check returns.
  task automatic tick();
    int g;
    int idx;
    logic [NREQ-1:0] er;
    pend_t p;
    drive();
    #1;
    g = -1;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (last_gnt + k) % NREQ;
      if (g < 0 && vld[idx]) g = idx;
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", req_ready_o, er);
    chk("mul_a", mul_a_o, (g >= 0) ? a_op[g] : 31'd0);
    chk("mul_b", mul_b_o, (g >= 0) ? b_op[g] : 31'd0);
    if (g >= 0) begin
      p.owner = g;
      p.data  = mulmod(a_op[g], b_op[g]);
      p.due   = cyc + MUL_LAT + 1;
      sb.push_back(p);
      last_gnt = g;
    end
    granted = g;
    @(negedge clk);
    cyc++;
    er = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      er[sb[0].owner] = 1'b1;
      chk("rsp_data", rsp_data_o, sb[0].data);
      void'(sb.pop_front());
    end
    chk("rsp_valid", rsp_valid_o, er);
    chk("busy", busy_o, sb.size() != 0);
  endtask

  // Holds reset for n cycles with every requester valid, checking outputs stay quiet.
  task automatic do_reset(input int n);
    vld = '1;
    drive();
    rst_n = 1'b1;
    repeat (n) @(negedge clk);
    #1;
    chk("rst_ready", req_ready_o, 4'b0000);
    chk("rst_rsp", rsp_valid_o, 4'b0000);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_mul_a", mul_a_o, 31'd0);
    chk("rst_mul_b", mul_b_o, 31'd0);
    @(negedge clk);
    rst_n    = 1'b0;
    vld      = '0;
    sb.delete();
    last_gnt = NREQ - 1;
  endtask

  function automatic logic [30:0] rand_op();
    case ($urandom_range(7))
      0:       return 31'd0;
      1:       return 31'h7fff_ffff;
      2:       return 31'h7fff_fffe;
      default: return 31'($urandom);
    endcase
  endfunction

  typedef struct { int req; logic [30:0] a; logic [30:0] b; logic [30:0] exp_data; logic [NREQ-1:0] exp_rsp; } vec_t;
  vec_t vecs [7];

  initial begin
    cyc      = 0;
    last_gnt = NREQ - 1;
    granted  = -1;
    vld      = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_op[i] = 31'(32'h1111_1111 * (i + 1));
      b_op[i] = 31'(32'h0202_0202 * (i + 3));
    end
    rst_n = 1'b1;
    drive();

    vecs[0] = '{0, 31'h7fff_fffe, 31'h7fff_fffe, 31'h0000_0001, 4'b0001};
    vecs[1] = '{1, 31'h0000_0002, 31'h0000_0003, 31'h0000_0006, 4'b0010};
    vecs[2] = '{2, 31'h2e41_3a1f, 31'h1633_2d59, mulmod(31'h2e41_3a1f, 31'h1633_2d59), 4'b0100};
    vecs[3] = '{3, 31'h4000_0000, 31'h0000_0002, 31'h0000_0001, 4'b1000};
    vecs[4] = '{0, 31'h7fff_ffff, 31'h0000_0005, 31'h0000_0000, 4'b0001};
    vecs[5] = '{1, 31'h0000_0000, 31'h0000_1234, 31'h0000_0000, 4'b0010};
    vecs[6] = '{3, 31'h0001_0000, 31'h0001_0000, 31'h0000_0002, 4'b1000};

    @(negedge clk);
    do_reset(3);

    // Single isolated operations: result must land exactly MUL_LAT edges after transfer.
    for (int v = 0; v < 7; v++) begin
      vld = '0;
      vld[vecs[v].req] = 1'b1;
      a_op[vecs[v].req] = vecs[v].a;
      b_op[vecs[v].req] = vecs[v].b;
      tick();
      vld = '0;
      repeat (MUL_LAT) tick();
      chk("vec_rsp_valid", rsp_valid_o, vecs[v].exp_rsp);
      chk("vec_rsp_data", rsp_data_o, vecs[v].exp_data);
      tick();
    end

    // Requester 2, then requester 1 on the next cycle: returns on consecutive cycles.
    vld = 4'b0100;
    tick();
    vld = 4'b0010;
    tick();
    vld = '0;
    repeat (3) tick();
    chk("r2_then_r1_first", rsp_valid_o, 4'b0100);
    tick();
    chk("r2_then_r1_second", rsp_valid_o, 4'b0010);
    repeat (2) tick();

    // All requesters valid continuously from reset: full-throughput round robin.
    do_reset(2);
    vld = '1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("rr_order", granted, i % NREQ);
      chk("rr_busy", busy_o, 1'b1);
    end
    vld = '0;
    repeat (MUL_LAT + 2) tick();

    // Reset in the middle of three in-flight operations discards them.
    vld = '1;
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    chk("midrst_busy", busy_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    last_gnt = NREQ - 1;
    vld = '0;
    repeat (MUL_LAT + 3) tick();
    vld = '1;
    tick();
    chk("midrst_next_grant", granted, 0);
    vld = '0;
    repeat (MUL_LAT + 2) tick();

    // Wrap-around: last grant to 3, then 0 and 3 both valid -> 0 wins.
    vld = 4'b1000;
    tick();
    vld = 4'b1001;
    tick();
    chk("wrap_grant", granted, 0);
    vld = '0;
    repeat (MUL_LAT + 2) tick();

    // Randomized traffic with holds, withdrawals and fresh requests.
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (vld[i]) begin
          if ($urandom_range(15) == 0) vld[i] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          vld[i]  = 1'b1;
          a_op[i] = rand_op();
          b_op[i] = rand_op();
        end
      end
      tick();
      if (granted >= 0) vld[granted] = 1'b0;
    end
    vld = '0;
    repeat (MUL_LAT + 2) tick();
    chk("drain_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
